// File: rtl/irda_sir_tx.sv
// IrDA SIR byte transmitter: UART 8N1 framing with return-to-zero pulses for 0 bits,
// plus transceiver shutdown control with a wake-up settle period.
module irda_sir_tx #(
  parameter int BIT_CYCLES   = 1250,
  parameter int PULSE_CYCLES = 234,
  parameter int WAKE_CYCLES  = 1200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       txd,
  output logic       sd
);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam int WW = $clog2(WAKE_CYCLES + 1);
  localparam logic [CW-1:0] CELL_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] DONE_AT   = CW'(BIT_CYCLES - 2);
  localparam logic [CW-1:0] PULSE_END = CW'(PULSE_CYCLES);
  localparam logic [WW-1:0] WAKE_LOAD = WW'(WAKE_CYCLES - 1);

  typedef enum logic [2:0] {S_OFF, S_WAKE, S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state;
  logic [CW-1:0]   cell_cnt;
  logic [CW-1:0]   cell_inc;
  logic [WW-1:0]   wake_cnt;
  logic [3:0]      bit_idx;
  logic [8:0]      shreg;   // remaining data bits, stop bit shifted in from the top

  assign cell_inc = cell_cnt + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_OFF;
      cell_cnt <= '0;
      wake_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      txd      <= 1'b0;
      sd       <= 1'b1;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_OFF: begin
          if (enable) begin
            state    <= S_WAKE;
            wake_cnt <= WAKE_LOAD;
            sd       <= 1'b0;
          end
        end
        S_WAKE: begin
          if (!enable) begin
            state <= S_OFF;
            sd    <= 1'b1;
          end else if (wake_cnt == '0) begin
            state    <= S_IDLE;
            tx_ready <= 1'b1;
          end else begin
            wake_cnt <= wake_cnt - WW'(1);
          end
        end
        S_IDLE: begin
          // An advertised ready is honoured even if enable falls in the same cycle.
          if (tx_valid && tx_ready) begin
            state    <= S_START;
            shreg    <= {1'b1, tx_data};
            cell_cnt <= '0;
            bit_idx  <= '0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            txd      <= 1'b1;
          end else if (!enable) begin
            state    <= S_OFF;
            sd       <= 1'b1;
            tx_ready <= 1'b0;
          end else begin
            tx_ready <= 1'b1;
          end
        end
        default: begin
          if (cell_cnt == CELL_LAST) begin
            cell_cnt <= '0;
            if (state == S_STOP) begin
              state    <= S_IDLE;
              bit_idx  <= '0;
              busy     <= 1'b0;
              tx_ready <= enable;
              txd      <= 1'b0;
            end else begin
              state   <= (bit_idx == 4'd8) ? S_STOP : S_DATA;
              bit_idx <= bit_idx + 4'd1;
              txd     <= ~shreg[0];
              shreg   <= {1'b1, shreg[8:1]};
            end
          end else begin
            cell_cnt <= cell_inc;
            if (cell_inc == PULSE_END) txd <= 1'b0;
            if (state == S_STOP && cell_cnt == DONE_AT) done <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule
